// File: rtl/fpu_sequencer.sv
// Issue/sequencing controller between mainfsm and the FPU: latches one op, holds operands for
// the per-op latency, captures the result and pulses a one-cycle writeback. Optional FPU_FLAGS_EN.
module fpu_sequencer #(
  parameter int unsigned LAT_ADD = 2,
  parameter int unsigned LAT_MUL = 3,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [1:0]  op,
  input  logic        prec,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [3:0]  Rd,
  input  logic [31:0] fpu_result,
  input  logic [3:0]  fpu_nzcv,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_op,
  output logic        fpu_prec,
  output logic        busy,
  output logic        done,
  output logic        RegWriteFP,
  output logic [31:0] Result,
  output logic [3:0]  RdOut,
  output logic        err,
  output logic [3:0]  FlagsOut,
  output logic        FlagWrite
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [CNT_W-1:0] LAT_ADD_M1 = CNT_W'(LAT_ADD - 1);
  localparam logic [CNT_W-1:0] LAT_MUL_M1 = CNT_W'(LAT_MUL - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d, result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic             prec_q, prec_d;
  logic [3:0]       rd_q, rd_d, rdout_q, rdout_d;
  logic             accept, capture;

  // A new op may be accepted from IDLE or from WB (back-to-back issue).
  assign accept  = start & ~flush & ((state_q == S_IDLE) | (state_q == S_WB));
  assign capture = ~flush & (state_q == S_WAIT) & (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    prec_d   = prec_q;
    rd_d     = rd_q;
    result_d = result_q;
    rdout_d  = rdout_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_ISSUE;
        S_ISSUE: begin
          if (op_q == OP_RSV) begin
            state_d = S_WB;
          end else begin
            state_d = S_WAIT;
            cnt_d   = (op_q == OP_MUL) ? LAT_MUL_M1 : LAT_ADD_M1;
          end
        end
        S_WAIT:  begin
          if (cnt_q == '0) state_d = S_WB;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = start ? S_ISSUE : S_IDLE;
      endcase
    end
    if (accept) begin
      a_d    = SrcA;
      b_d    = SrcB;
      op_d   = op;
      prec_d = prec;
      rd_d   = Rd;
    end
    if (capture) begin
      result_d = {prec_q ? fpu_result[31:16] : 16'h0000, fpu_result[15:0]};
      rdout_d  = rd_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      prec_q   <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      rdout_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      prec_q   <= prec_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rdout_q  <= rdout_d;
    end
  end

  assign fpu_a      = a_q;
  assign fpu_b      = b_q;
  assign fpu_op     = op_q;
  assign fpu_prec   = prec_q;
  assign busy       = (state_q == S_ISSUE) | (state_q == S_WAIT);
  assign done       = (state_q == S_WB);
  assign RegWriteFP = done & (op_q != OP_RSV);
  assign err        = done & (op_q == OP_RSV);
  assign Result     = result_q;
  assign RdOut      = rdout_q;

`ifdef FPU_FLAGS_EN
  logic [3:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (capture) flags_d = fpu_nzcv;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign FlagsOut  = flags_q;
  assign FlagWrite = done & (op_q == OP_SUB);
`else
  logic unused_nzcv;
  assign unused_nzcv = ^fpu_nzcv;
  assign FlagsOut    = '0;
  assign FlagWrite   = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer: expected writebacks are queued at issue and checked on done.
module tb_fpu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, start, flush, prec;
  logic [1:0]  op;
  logic [31:0] SrcA, SrcB, fpu_result;
  logic [3:0]  Rd, fpu_nzcv;
  logic [31:0] fpu_a, fpu_b, Result;
  logic [1:0]  fpu_op;
  logic        fpu_prec, busy, done, RegWriteFP, err, FlagWrite;
  logic [3:0]  RdOut, FlagsOut;

  fpu_sequencer #(.LAT_ADD(2), .LAT_MUL(3), .CNT_W(4)) dut (
    .clk(clk), .reset(rst_n), .start(start), .flush(flush), .op(op), .prec(prec),
    .SrcA(SrcA), .SrcB(SrcB), .Rd(Rd), .fpu_result(fpu_result), .fpu_nzcv(fpu_nzcv),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_prec(fpu_prec), .busy(busy),
    .done(done), .RegWriteFP(RegWriteFP), .Result(Result), .RdOut(RdOut), .err(err),
    .FlagsOut(FlagsOut), .FlagWrite(FlagWrite)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in FPU: known answers for the reference vectors, a scrambling function otherwise.
  function automatic logic [31:0] fmodel(logic [1:0] o, logic p, logic [31:0] a, logic [31:0] b);
    if (o == 2'b00 && !p && a == 32'h3C00 && b == 32'h3C00) return 32'hDEAD4000;
    if (o == 2'b10 && p && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    return a ^ {b[15:0], b[31:16]} ^ {30'b0, o};
  endfunction
  assign fpu_result = fmodel(fpu_op, fpu_prec, fpu_a, fpu_b);

  typedef struct {
    int unsigned cyc;
    logic [31:0] res;
    logic [3:0]  rd;
    logic        err;
    logic        rwe;
    logic [3:0]  fl;
    logic        fw;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_res = '0;
  logic [3:0]  last_rd = '0, last_fl = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse; when expect_wb is set, queue the writeback the op must produce.
  task automatic issue(input logic [1:0] o, input logic p, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] rd, input logic [3:0] nz,
                       input bit expect_wb);
    exp_t e;
    logic [31:0] r;
    int unsigned lat;
    op = o; prec = p; SrcA = a; SrcB = b; Rd = rd; fpu_nzcv = nz; start = 1'b1;
    lat = (o == 2'b10) ? 3 : (o == 2'b11) ? 0 : 2;
    if (expect_wb) begin
      e.cyc = cyc + lat + 2;
      if (o == 2'b11) begin
        e.res = last_res; e.rd = last_rd; e.err = 1'b1; e.rwe = 1'b0; e.fl = last_fl; e.fw = 1'b0;
      end else begin
        r = fmodel(o, p, a, b);
        e.res = p ? r : {16'h0, r[15:0]};
        e.rd = rd; e.err = 1'b0; e.rwe = 1'b1;
`ifdef FPU_FLAGS_EN
        e.fl = nz; e.fw = (o == 2'b01);
`else
        e.fl = 4'h0; e.fw = 1'b0;
`endif
        last_res = e.res; last_rd = rd; last_fl = e.fl;
      end
      sb.push_back(e);
    end
    step();
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'b0, done}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("Result", Result, e.res);
        chk("RdOut", {28'b0, RdOut}, {28'b0, e.rd});
        chk("err", {31'b0, err}, {31'b0, e.err});
        chk("RegWriteFP", {31'b0, RegWriteFP}, {31'b0, e.rwe});
        chk("FlagsOut", {28'b0, FlagsOut}, {28'b0, e.fl});
        chk("FlagWrite", {31'b0, FlagWrite}, {31'b0, e.fw});
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; prec = 1'b0;
    SrcA = '0; SrcB = '0; Rd = '0; fpu_nzcv = '0;
    #2;
    chk("reset_ctrl", {16'b0, busy, done, RegWriteFP, err, FlagWrite, RdOut, FlagsOut, fpu_op, fpu_prec}, 32'h0);
    chk("reset_Result", Result, 32'h0);
    chk("reset_fpu_a", fpu_a, 32'h0);
    chk("reset_fpu_b", fpu_b, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // fp16 ADD followed by fp32 MUL issued in the ADD's WB cycle
    issue(2'b00, 1'b0, 32'h3C00, 32'h3C00, 4'd5, 4'h0, 1'b1);
    chk("add_busy_issue", {31'b0, busy}, 32'h1);
    chk("add_fpu_a", fpu_a, 32'h3C00);
    step(); step();
    chk("add_busy_wait", {31'b0, busy}, 32'h1);
    step();
    chk("add_wb_not_busy", {31'b0, busy}, 32'h0);
    issue(2'b10, 1'b1, 32'h40000000, 32'h40400000, 4'd7, 4'h0, 1'b1);
    chk("b2b_issue_busy", {31'b0, busy}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mul_fpu_a_stable", fpu_a, 32'h40000000);
      chk("mul_fpu_b_stable", fpu_b, 32'h40400000);
    end
    step();
    step();

    // start while busy is ignored; flush in WAIT aborts; flush beats start
    issue(2'b10, 1'b1, 32'h1234, 32'h5678, 4'd2, 4'h0, 1'b0);
    step();
    op = 2'b00; SrcA = 32'hFFFFFFFF; start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_ignored_a", fpu_a, 32'h1234);
    chk("busy_start_ignored_op", {30'b0, fpu_op}, 32'h2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_idle", {31'b0, busy}, 32'h0);
    chk("flush_Result_kept", Result, last_res);
    flush = 1'b1; start = 1'b1; SrcA = 32'hAAAA;
    step();
    flush = 1'b0; start = 1'b0;
    chk("flush_start_busy", {31'b0, busy}, 32'h0);
    chk("flush_start_nolatch", fpu_a, 32'h1234);
    for (int i = 0; i < 5; i++) step();

    // reserved op, then reset asserted mid-WAIT
    issue(2'b11, 1'b1, 32'h1, 32'h2, 4'd9, 4'h0, 1'b1);
    step(); step();
    issue(2'b01, 1'b1, 32'h11111111, 32'h22222222, 4'd4, 4'h0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    last_res = '0; last_rd = '0; last_fl = '0;
    chk("midreset_ctrl", {16'b0, busy, done, RegWriteFP, err, FlagWrite, RdOut, FlagsOut, fpu_op, fpu_prec}, 32'h0);
    chk("midreset_Result", Result, 32'h0);
    chk("midreset_fpu_a", fpu_a, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // flag capture: SUB writes flags, ADD does not
    issue(2'b01, 1'b1, 32'h3F800000, 32'h40000000, 4'd3, 4'b0110, 1'b1);
    step(); step(); step(); step();
    issue(2'b00, 1'b1, 32'hCAFE0001, 32'h0BAD0002, 4'd12, 4'b1001, 1'b1);
    step(); step(); step(); step();
    issue(2'b01, 1'b0, 32'h12345678, 32'h9ABCDEF0, 4'd15, 4'b1010, 1'b1);
    for (int i = 0; i < 8; i++) step();

    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
